// File: rtl/turn_timer.sv
// Countdown turn timer: loads a clamped seconds value, counts down on each
// synchronized 1 Hz tick edge, supports pause/clear, and drives BCD digits.
module turn_timer #(
  parameter int MAX_SEC = 99
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_in,
  input  logic       start,
  input  logic       pause,
  input  logic       clear,
  input  logic [6:0] load_val,
  output logic [6:0] remaining,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       running,
  output logic       expired,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t     state;
  logic       tick_p0;
  logic       tick_p1;
  logic       tick_p2;
  logic       tick_evt;
  logic [6:0] load_sat;

  function automatic logic [6:0] clamp_sec(input logic [6:0] v);
    return (v > 7'(MAX_SEC)) ? 7'(MAX_SEC) : v;
  endfunction

  assign load_sat = clamp_sec(load_val);

  // Stage p0/p1: two-flop synchronizer; p2: history flop for edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_p0 <= 1'b0;
      tick_p1 <= 1'b0;
      tick_p2 <= 1'b0;
    end else begin
      tick_p0 <= tick_in;
      tick_p1 <= tick_p0;
      tick_p2 <= tick_p1;
    end
  end

  assign tick_evt = tick_p1 & ~tick_p2;

  // Control FSM; clear beats start, start beats pause and tick
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      remaining <= 7'd0;
      running   <= 1'b0;
      expired   <= 1'b0;
      done      <= 1'b0;
    end else begin
      expired <= 1'b0;
      if (clear) begin
        state     <= IDLE;
        remaining <= 7'd0;
        running   <= 1'b0;
        done      <= 1'b0;
      end else if (start) begin
        if (load_sat != 7'd0) begin
          state     <= RUN;
          remaining <= load_sat;
          running   <= 1'b1;
          done      <= 1'b0;
        end else begin
          state     <= DONE;
          remaining <= 7'd0;
          running   <= 1'b0;
          done      <= 1'b1;
          expired   <= 1'b1;
        end
      end else begin
        case (state)
          RUN: begin
            if (pause) begin
              state   <= HOLD;
              running <= 1'b0;
            end else if (tick_evt) begin
              if (remaining <= 7'd1) begin
                state     <= DONE;
                remaining <= 7'd0;
                running   <= 1'b0;
                done      <= 1'b1;
                expired   <= 1'b1;
              end else begin
                remaining <= remaining - 7'd1;
              end
            end
          end
          HOLD: begin
            if (!pause) begin
              state   <= RUN;
              running <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Display digits follow remaining with no added latency
  always_comb begin
    tens = 4'd0;
    for (int d = 1; d <= 9; d++) begin
      if (remaining >= 7'(d * 10)) tens = 4'(d);
    end
    ones = 4'(remaining - 7'(tens) * 7'd10);
  end

endmodule

// File: tb/tb_turn_timer.sv
// Bench for turn_timer: vector table, timing-critical sequences, and random
// operations checked against an operation-level reference model.
module tb_turn_timer;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick_in;
  logic       start;
  logic       pause;
  logic       clear;
  logic [6:0] load_val;
  logic [6:0] remaining;
  logic [3:0] tens;
  logic [3:0] ones;
  logic       running;
  logic       expired;
  logic       done;

  turn_timer #(.MAX_SEC(99)) dut (
    .clk(clk), .rst(rst), .tick_in(tick_in), .start(start), .pause(pause),
    .clear(clear), .load_val(load_val), .remaining(remaining), .tens(tens),
    .ones(ones), .running(running), .expired(expired), .done(done)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int exp_seen = 0;

  always @(negedge clk) if (expired === 1'b1) exp_seen++;

  // Reference model state, at the level of whole operations
  int m_rem = 0;
  bit m_active = 0;
  bit m_done = 0;
  int m_exp = 0;

  localparam int OP_START = 0, OP_TICK = 1, OP_PAUSE = 2, OP_CLEAR = 3, OP_STCLR = 4;

  typedef struct {
    int op;
    int load;
    int pz;
    int rem;
    bit run;
    bit dn;
  } vec_t;

  vec_t tbl[18];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_out(input string name, input int er, input bit erun, input bit edn);
    chk({name, ".remaining"}, int'(remaining), er);
    chk({name, ".tens"}, int'(tens), er / 10);
    chk({name, ".ones"}, int'(ones), er % 10);
    chk({name, ".running"}, int'(running), int'(erun));
    chk({name, ".done"}, int'(done), int'(edn));
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic m_start(input int v);
    int c;
    c = (v > 99) ? 99 : v;
    if (c == 0) begin
      m_rem = 0; m_active = 0; m_done = 1; m_exp++;
    end else begin
      m_rem = c; m_active = 1; m_done = 0;
    end
  endtask

  task automatic m_clear();
    m_rem = 0; m_active = 0; m_done = 0;
  endtask

  task automatic m_tick();
    if (m_active && !pause) begin
      m_rem = m_rem - 1;
      if (m_rem == 0) begin
        m_active = 0; m_done = 1; m_exp++;
      end
    end
  endtask

  task automatic op_start(input int v);
    load_val = 7'(v); start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    m_start(v);
  endtask

  task automatic op_tick();
    tick_in = 1'b1;
    repeat (3) cyc();
    tick_in = 1'b0;
    repeat (3) cyc();
    m_tick();
  endtask

  task automatic op_pause(input int p);
    pause = p[0];
    cyc();
    cyc();
  endtask

  task automatic op_clear();
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    cyc();
    m_clear();
  endtask

  task automatic op_stclr(input int v);
    load_val = 7'(v); start = 1'b1; clear = 1'b1;
    cyc();
    start = 1'b0; clear = 1'b0;
    cyc();
    m_clear();
  endtask

  task automatic do_op(input int op, input int load, input int pz);
    case (op)
      OP_START: op_start(load);
      OP_TICK:  op_tick();
      OP_PAUSE: op_pause(pz);
      OP_CLEAR: op_clear();
      default:  op_stclr(load);
    endcase
  endtask

  initial begin
    tbl[0]  = '{OP_START, 3,   0, 3,  1, 0};
    tbl[1]  = '{OP_TICK,  0,   0, 2,  1, 0};
    tbl[2]  = '{OP_TICK,  0,   0, 1,  1, 0};
    tbl[3]  = '{OP_TICK,  0,   0, 0,  0, 1};
    tbl[4]  = '{OP_START, 45,  0, 45, 1, 0};
    tbl[5]  = '{OP_PAUSE, 0,   1, 45, 0, 0};
    tbl[6]  = '{OP_TICK,  0,   0, 45, 0, 0};
    tbl[7]  = '{OP_PAUSE, 0,   0, 45, 1, 0};
    tbl[8]  = '{OP_TICK,  0,   0, 44, 1, 0};
    tbl[9]  = '{OP_START, 120, 0, 99, 1, 0};
    tbl[10] = '{OP_START, 0,   0, 0,  0, 1};
    tbl[11] = '{OP_START, 10,  0, 10, 1, 0};
    tbl[12] = '{OP_STCLR, 50,  0, 0,  0, 0};
    tbl[13] = '{OP_TICK,  0,   0, 0,  0, 0};
    tbl[14] = '{OP_START, 1,   0, 1,  1, 0};
    tbl[15] = '{OP_TICK,  0,   0, 0,  0, 1};
    tbl[16] = '{OP_TICK,  0,   0, 0,  0, 1};
    tbl[17] = '{OP_CLEAR, 0,   0, 0,  0, 0};

    rst = 1'b0; tick_in = 1'b0; start = 1'b0; pause = 1'b0;
    clear = 1'b0; load_val = 7'd0;
    #3;
    chk_out("reset", 0, 0, 0);
    chk("reset.expired", int'(expired), 0);
    cyc(); cyc();
    rst = 1'b1;
    cyc();

    for (int i = 0; i < 18; i++) begin
      do_op(tbl[i].op, tbl[i].load, tbl[i].pz);
      chk_out($sformatf("tbl%0d", i), tbl[i].rem, tbl[i].run, tbl[i].dn);
    end
    chk("tbl.expired_count", exp_seen, 3);

    // Tick latency: change exactly at the third edge after tick_in rises
    op_start(45);
    tick_in = 1'b1;
    cyc(); chk("lat.edge1", int'(remaining), 45);
    cyc(); chk("lat.edge2", int'(remaining), 45);
    cyc(); chk_out("lat.edge3", 44, 1, 0);
    tick_in = 1'b0;
    repeat (3) cyc();

    // Expired pulse timing on the final tick
    op_start(1);
    tick_in = 1'b1;
    cyc(); cyc();
    chk("exp.before", int'(expired), 0);
    cyc();
    chk("exp.on_edge", int'(expired), 1);
    chk_out("exp.on_edge", 0, 0, 1);
    cyc();
    chk("exp.after", int'(expired), 0);
    tick_in = 1'b0;
    repeat (3) cyc();

    // Zero load: expired pulse right after the start edge, then drops
    load_val = 7'd0; start = 1'b1;
    cyc();
    start = 1'b0;
    chk("zero.expired", int'(expired), 1);
    chk_out("zero", 0, 0, 1);
    cyc();
    chk("zero.expired_after", int'(expired), 0);

    // Tick event on the same edge as start does not touch the new value
    op_start(20);
    tick_in = 1'b1;
    cyc(); cyc();
    load_val = 7'd7; start = 1'b1;
    cyc();
    start = 1'b0;
    chk_out("coincide", 7, 1, 0);
    repeat (3) cyc();
    chk("coincide.later", int'(remaining), 7);
    tick_in = 1'b0;
    repeat (3) cyc();

    // Asynchronous reset mid-countdown
    op_start(5);
    cyc();
    #2 rst = 1'b0;
    #1;
    chk_out("async_rst", 0, 0, 0);
    chk("async_rst.expired", int'(expired), 0);
    cyc();
    rst = 1'b1;
    op_tick();
    op_tick();
    chk_out("rst_idle_ticks", 0, 0, 0);

    // tick_in already high at reset release: one event, seen only in RUN
    tick_in = 1'b1;
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    load_val = 7'd9; start = 1'b1;
    cyc();
    start = 1'b0;
    cyc(); cyc();
    chk_out("rel_high_run", 8, 1, 0);
    repeat (4) cyc();
    chk("rel_high_run.hold", int'(remaining), 8);
    tick_in = 1'b0;
    repeat (3) cyc();

    // Random operations against the reference model
    pause = 1'b0;
    op_clear();
    m_exp = 0;
    exp_seen = 0;
    for (int n = 0; n < 150; n++) begin
      int r;
      int v;
      r = int'($urandom_range(0, 99));
      v = (($urandom_range(0, 3)) == 0) ? int'($urandom_range(0, 127)) : int'($urandom_range(0, 6));
      if (r < 45)      do_op(OP_TICK, 0, 0);
      else if (r < 65) do_op(OP_START, v, 0);
      else if (r < 80) do_op(OP_PAUSE, 0, int'($urandom_range(0, 1)));
      else if (r < 90) do_op(OP_CLEAR, 0, 0);
      else if (r < 95) do_op(OP_STCLR, v, 0);
      else             cyc();
      chk_out($sformatf("rand%0d", n), m_rem, m_active && !pause, m_done);
    end
    cyc();
    chk("rand.expired_count", exp_seen, m_exp);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
